pattern_tx_58: RTL and testbench

PATTERN_TX_58 -- requirements
Module: pattern_tx_58

---
 rtl/pattern_tx_58.sv | 174 +++++++++++++++++
 tb/tb_pattern_tx_58.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx_58.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pattern_tx_58
// Serial pattern transmitter. On a start request in IDLE it sends PATTERN
// MSB first, repeated `count` times (0 means 16). Repetitions are separated
// by GAP idle-zero cycles. A one-cycle done pulse follows a completed burst.
// Every output is registered.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   asynchronous, active-low reset
//   start  in   burst request, sampled only in IDLE
//   count  in   [3:0] repetitions per burst, latched with start (0 = 16)
//   abort  in   forces IDLE at the next edge from any state, with no done
//   out    out  serial bit stream
//   valid  out  high while out carries a pattern bit
//   busy   out  high in SEND or GAP
//   done   out  one-cycle pulse after the final bit of a burst
//   sof    out  one-cycle pulse with the first bit of each repetition
// ---------------------------------------------------------------------------
module pattern_tx_58 #(
  parameter logic [7:0] PATTERN = 8'h58,
  parameter int         GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       abort,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       sof
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LEN = 4'(GAP);

  state_t     state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  // Five bits so that count=0 can hold 16 remaining repetitions.
  logic [4:0] rep_q, rep_d;
  logic       out_q, out_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sof_q, sof_d;

  // Next-state and registered-output computation. Outputs default to the
  // idle values so that every state only states what it drives high.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    rep_d     = rep_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sof_d     = 1'b0;

    if (abort) begin
      state_d   = S_IDLE;
      bit_idx_d = 3'd0;
      gap_cnt_d = 4'd0;
      rep_d     = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_SEND;
            bit_idx_d = 3'd7;
            rep_d     = (count == 4'd0) ? 5'd16 : {1'b0, count};
            out_d     = PATTERN[7];
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            sof_d     = 1'b1;
          end
        end

        S_SEND: begin
          busy_d = 1'b1;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
            out_d     = PATTERN[bit_idx_d];
            valid_d   = 1'b1;
          end else begin
            // Last bit of this repetition is on the line now.
            rep_d = rep_q - 5'd1;
            if (rep_q > 5'd1) begin
              if (GAP_LEN != 4'd0) begin
                state_d   = S_GAP;
                gap_cnt_d = GAP_LEN - 4'd1;
              end else begin
                state_d   = S_SEND;
                bit_idx_d = 3'd7;
                out_d     = PATTERN[7];
                valid_d   = 1'b1;
                sof_d     = 1'b1;
              end
            end else begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end

        S_GAP: begin
          busy_d = 1'b1;
          if (gap_cnt_q == 4'd0) begin
            state_d   = S_SEND;
            bit_idx_d = 3'd7;
            out_d     = PATTERN[7];
            valid_d   = 1'b1;
            sof_d     = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end

        S_DONE: begin
          // start is deliberately not sampled here.
          state_d = S_IDLE;
          rep_d   = 5'd0;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_idx_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      rep_q     <= 5'd0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      rep_q     <= rep_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sof_q     <= sof_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sof   = sof_q;

endmodule

// File: tb/tb_pattern_tx_58.sv
`timescale 1ns/1ps
// Directed bench for pattern_tx_58: one instance with default GAP=2 and one
// with GAP=0. Outputs are sampled on the falling clock edge, which is also
// where inputs are changed.
module tb_pattern_tx_58;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0, abort;
  logic [3:0] count, count0;
  logic       out, valid, busy, done, sof;
  logic       out0, valid0, busy0, done0, sof0;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int busy_seen = 0;
  int sof_seen  = 0;

  always #5 clk = ~clk;

  pattern_tx_58 dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
    .out(out), .valid(valid), .busy(busy), .done(done), .sof(sof)
  );

  pattern_tx_58 #(.PATTERN(8'h58), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .count(count0), .abort(abort),
    .out(out0), .valid(valid0), .busy(busy0), .done(done0), .sof(sof0)
  );

  // Observed output vector {out, valid, busy, done, sof}.
  function automatic logic [4:0] obs(input int which);
    if (which == 0) return {out, valid, busy, done, sof};
    return {out0, valid0, busy0, done0, sof0};
  endfunction

  // Expected vector at cycle c after the start edge, for n repetitions.
  function automatic logic [4:0] expVec(input int c, input int gap, input int n);
    logic [7:0] pat;
    int total, pos;
    pat   = 8'h58;
    total = 8 * n + gap * (n - 1);
    if (c < total) begin
      pos = c % (8 + gap);
      if (pos < 8) return {pat[7 - pos], 1'b1, 1'b1, 1'b0, (pos == 0)};
      return 5'b00100;
    end
    if (c == total) return 5'b00010;
    return 5'b00000;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    assert (actual === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] c, input logic a);
    start = s;
    count = c;
    abort = a;
    tick();
  endtask

  // Checks cycles from..to of a burst, advancing one clock per cycle.
  task automatic checkBurst(input int which, input int n, input int gap,
                            input int from, input int to, input string name);
    logic [4:0] v;
    for (int c = from; c <= to; c++) begin
      v = obs(which);
      if (v[2]) busy_seen++;
      if (v[0]) sof_seen++;
      checkOutput($sformatf("%s c=%0d", name, c), {27'd0, v}, {27'd0, expVec(c, gap, n)});
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0;
    count = 4'd0; count0 = 4'd0;
    #1 rst = 1'b0;
    #1 checkOutput("reset_async", {27'd0, obs(0)}, 32'd0);
    checkOutput("reset_async_gap0", {27'd0, obs(1)}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("idle_after_reset", {27'd0, obs(0)}, 32'd0);

    // Single repetition: bits 0,1,0,1,1,0,0,0 then done.
    applyStimulus(1'b1, 4'd1, 1'b0);
    start = 1'b0;
    checkOutput("single_first_bit", {27'd0, obs(0)}, 32'b01101);
    checkBurst(0, 1, 2, 0, 9, "single");

    // Three repetitions with gap 2; a start mid-burst must be ignored.
    busy_seen = 0; sof_seen = 0;
    applyStimulus(1'b1, 4'd3, 1'b0);
    start = 1'b0;
    checkBurst(0, 3, 2, 0, 11, "triple");
    start = 1'b1; count = 4'd5;
    checkBurst(0, 3, 2, 12, 12, "triple");
    start = 1'b0;
    checkBurst(0, 3, 2, 13, 29, "triple");
    checkOutput("triple_busy_cycles", busy_seen, 28);
    checkOutput("triple_sof_count", sof_seen, 3);

    // Abort at bit 4 of repetition 2, then a fresh burst.
    applyStimulus(1'b1, 4'd3, 1'b0);
    start = 1'b0;
    checkBurst(0, 3, 2, 0, 13, "pre_abort");
    checkOutput("pre_abort c=14", {27'd0, obs(0)}, {27'd0, expVec(14, 2, 3)});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_idle", {27'd0, obs(0)}, 32'd0);
    tick();
    checkOutput("abort_no_done", {27'd0, obs(0)}, 32'd0);
    applyStimulus(1'b1, 4'd1, 1'b0);
    start = 1'b0;
    checkBurst(0, 1, 2, 0, 9, "after_abort");

    // Abort beats start in IDLE.
    applyStimulus(1'b1, 4'd2, 1'b1);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_wins", {27'd0, obs(0)}, 32'd0);
    tick();
    checkOutput("abort_wins_hold", {27'd0, obs(0)}, 32'd0);

    // Reset pulsed between edges during the gap.
    applyStimulus(1'b1, 4'd2, 1'b0);
    start = 1'b0;
    checkBurst(0, 2, 2, 0, 7, "pre_rst");
    checkOutput("in_gap", {27'd0, obs(0)}, 32'b00100);
    #1 rst = 1'b0;
    #1 checkOutput("rst_mid_gap", {27'd0, obs(0)}, 32'd0);
    #1 rst = 1'b1;
    tick();
    checkOutput("post_rst_idle", {27'd0, obs(0)}, 32'd0);
    tick();
    checkOutput("post_rst_idle2", {27'd0, obs(0)}, 32'd0);

    // Start on the first edge after reset release is honoured.
    rst = 1'b0;
    #1 rst = 1'b1;
    start = 1'b1; count = 4'd1;
    tick();
    start = 1'b0;
    checkBurst(0, 1, 2, 0, 9, "after_rst_release");

    // start held high: two repetitions, DONE, IDLE, then a new burst.
    busy_seen = 0;
    applyStimulus(1'b1, 4'd2, 1'b0);
    checkBurst(0, 2, 2, 0, 19, "held");
    checkOutput("held_busy_cycles", busy_seen, 18);
    checkOutput("held_restart", {27'd0, obs(0)}, 32'b01101);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("held_abort_idle", {27'd0, obs(0)}, 32'd0);

    // GAP=0, count=0: 16 back-to-back repetitions.
    busy_seen = 0; sof_seen = 0;
    start0 = 1'b1; count0 = 4'd0;
    tick();
    start0 = 1'b0;
    checkBurst(1, 16, 0, 0, 129, "gap0_x16");
    checkOutput("gap0_busy_cycles", busy_seen, 128);
    checkOutput("gap0_sof_count", sof_seen, 16);
    checkOutput("main_dut_quiet", {27'd0, obs(0)}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
